// File: rtl/sram_deltacache_dp_if.sv
// sram_deltacache_dp_if: clear, write and read bus of the delta-cache SRAM
interface sram_deltacache_dp_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_W     = 8
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_W;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  wr_cs_n;
    logic [NUM_BYTES-1:0]  wr_be;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_cs_n;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    modport master (
        output clr_req, wr_cs_n, wr_be, wr_addr, wr_data, rd_cs_n, rd_addr,
        input  clr_busy, rd_data, rd_valid
    );
    modport slave (
        input  clr_req, wr_cs_n, wr_be, wr_addr, wr_data, rd_cs_n, rd_addr,
        output clr_busy, rd_data, rd_valid
    );
endinterface

// File: rtl/sram_deltacache_dp.sv
// sram_deltacache_dp: 1W1R delta-cache SRAM with byte lanes, sequential clear and optional output stage
module sram_deltacache_dp #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int BYTE_W     = 8,
    parameter int OUT_REG    = 0,
    parameter int WT_BYPASS  = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    sram_deltacache_dp_if.slave bus
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_W;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] new_word, rd_word, d1;
    logic                  wr_en, rd_en, v1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == CLEAR && cnt != LAST) ? cnt + 1'b1 : '0;
        end
    end
    always_comb state_nxt = (state == CLEAR) ? ((cnt == LAST) ? IDLE : CLEAR)
                                             : (bus.clr_req ? CLEAR : IDLE);
    always_comb begin
        bus.clr_busy = (state == CLEAR);
        wr_en        = (state == IDLE) && !bus.wr_cs_n && (32'(bus.wr_addr) < MEM_DEPTH);
        rd_en        = (state == IDLE) && !bus.rd_cs_n;
    end
    // Merged word is shared by the array write and the same-address bypass
    always_comb begin
        new_word = mem[bus.wr_addr];
        for (int b = 0; b < NUM_BYTES; b++)
            if (bus.wr_be[b]) new_word[b*BYTE_W +: BYTE_W] = bus.wr_data[b*BYTE_W +: BYTE_W];
        rd_word = (32'(bus.rd_addr) >= MEM_DEPTH) ? '0 :
                  (WT_BYPASS != 0 && wr_en && bus.rd_addr == bus.wr_addr) ? new_word :
                  mem[bus.rd_addr];
    end
    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[cnt] <= '0;
        else if (wr_en) mem[bus.wr_addr] <= new_word;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_en;
            if (rd_en) d1 <= rd_word;
        end
    end
    if (OUT_REG != 0) begin : g_out_reg
        logic                  v2;
        logic [DATA_WIDTH-1:0] d2;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= d1;
            end
        end
        assign bus.rd_valid = v2;
        assign bus.rd_data  = d2;
    end else begin : g_direct
        assign bus.rd_valid = v1;
        assign bus.rd_data  = d1;
    end
endmodule

// File: tb/tb_sram_deltacache_dp.sv
// tb_sram_deltacache_dp: random and directed traffic on two SRAM configurations, checked by a
// behavioural model feeding per-configuration expected-read queues drained by a monitor.
module tb_sram_deltacache_dp;
    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk, rst_n;
    logic        clr_req, wr_cs_n, rd_cs_n;
    logic [3:0]  wr_be;
    logic [5:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    int          checks = 0, errors = 0, cyc = 0;

    // dut0: defaults (depth 64, latency 1, bypass); dut1: depth 48, latency 2, no bypass
    sram_deltacache_dp_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .BYTE_W(8)) bus0 ();
    sram_deltacache_dp_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .BYTE_W(8)) bus1 ();
    sram_deltacache_dp dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    sram_deltacache_dp #(.MEM_DEPTH(48), .OUT_REG(1), .WT_BYPASS(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.clr_req = clr_req;  assign bus1.clr_req = clr_req;
    assign bus0.wr_cs_n = wr_cs_n;  assign bus1.wr_cs_n = wr_cs_n;
    assign bus0.wr_be   = wr_be;    assign bus1.wr_be   = wr_be;
    assign bus0.wr_addr = wr_addr;  assign bus1.wr_addr = wr_addr;
    assign bus0.wr_data = wr_data;  assign bus1.wr_data = wr_data;
    assign bus0.rd_cs_n = rd_cs_n;  assign bus1.rd_cs_n = rd_cs_n;
    assign bus0.rd_addr = rd_addr;  assign bus1.rd_addr = rd_addr;

    logic        busy_w [2], valid_w [2];
    logic [31:0] data_w [2];
    assign busy_w[0] = bus0.clr_busy;  assign busy_w[1] = bus1.clr_busy;
    assign valid_w[0] = bus0.rd_valid; assign valid_w[1] = bus1.rd_valid;
    assign data_w[0] = bus0.rd_data;   assign data_w[1] = bus1.rd_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dep(input int d);
        return d == 0 ? 64 : 48;
    endfunction
    function automatic int lat(input int d);
        return d == 0 ? 1 : 2;
    endfunction
    function automatic bit byp(input int d);
        return d == 0;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d got %h expected %h", nm, d, cyc, act, exp);
        end
    endtask

    // Reference model: array contents, remaining clear cycles, expected reads
    logic [31:0] mm [2][64];
    int          clr_left [2];
    logic [31:0] last [2];
    exp_t        q0 [$], q1 [$];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit          wr_ok;
        logic [31:0] nw, v;
        exp_t        e;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                clr_left[d] = dep(d);
                last[d] = 32'h0;
                if (d == 0) q0.delete(); else q1.delete();
            end else if (clr_left[d] > 0) begin
                mm[d][dep(d) - clr_left[d]] = 32'h0;
                clr_left[d]--;
            end else begin
                wr_ok = !wr_cs_n && int'(wr_addr) < dep(d);
                nw = merge(mm[d][wr_addr], wr_data, wr_be);
                if (!rd_cs_n) begin
                    if (int'(rd_addr) >= dep(d)) v = 32'h0;
                    else if (byp(d) && wr_ok && rd_addr == wr_addr) v = nw;
                    else v = mm[d][rd_addr];
                    e.data = v;
                    e.due = cyc + lat(d) - 1;
                    if (d == 0) q0.push_back(e); else q1.push_back(e);
                end
                if (wr_ok) mm[d][wr_addr] = nw;
                if (clr_req) clr_left[d] = dep(d);
            end
        end
    end

    always @(posedge clk) begin : monitor
        int   n;
        exp_t e;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("clr_busy", d, 32'(busy_w[d]), 32'(clr_left[d] > 0));
            n = (d == 0) ? q0.size() : q1.size();
            if (n > 0) e = (d == 0) ? q0[0] : q1[0];
            if (n > 0 && e.due == cyc) begin
                chk("rd_valid", d, 32'(valid_w[d]), 32'd1);
                chk("rd_data", d, data_w[d], e.data);
                last[d] = e.data;
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end else begin
                chk("rd_valid_idle", d, 32'(valid_w[d]), 32'd0);
                chk("rd_data_hold", d, data_w[d], last[d]);
            end
        end
    end

    task automatic drive(input logic wc, input logic [3:0] be, input logic [5:0] wa, input logic [31:0] wd,
                         input logic rc, input logic [5:0] ra, input logic cr);
        wr_cs_n = wc; wr_be = be; wr_addr = wa; wr_data = wd;
        rd_cs_n = rc; rd_addr = ra; clr_req = cr;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 6'd0, 1'b0);
    endtask

    task automatic rnd(input int n, input int clr_mod);
        logic [5:0] wa;
        for (int i = 0; i < n; i++) begin
            wa = 6'($urandom_range(0, 63));
            drive(1'($urandom_range(0, 1)), 4'($urandom), wa, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0 ? wa : 6'($urandom_range(0, 63)),
                  clr_mod > 0 && $urandom_range(0, clr_mod - 1) == 0);
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < 64; a++) drive(1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'(a), 1'b0);
    endtask

    task automatic fill();
        for (int a = 0; a < 64; a++) drive(1'b0, 4'hF, 6'(a), $urandom, 1'b1, 6'd0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        wr_cs_n = 1'b1; rd_cs_n = 1'b1; clr_req = 1'b0;
        wr_be = 4'h0; wr_addr = 6'd0; rd_addr = 6'd0; wr_data = 32'h0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(70);
        read_all();
        idle(3);
        drive(1'b0, 4'hF, 6'd5, 32'hDEADBEEF, 1'b1, 6'd0, 1'b0);
        drive(1'b0, 4'h5, 6'd5, 32'h11223344, 1'b1, 6'd0, 1'b0);
        drive(1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'd5, 1'b0);
        drive(1'b0, 4'hF, 6'd9, 32'hA5A5A5A5, 1'b0, 6'd9, 1'b0);
        drive(1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'd9, 1'b0);
        drive(1'b0, 4'hF, 6'd50, 32'h12345678, 1'b1, 6'd0, 1'b0);
        drive(1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'd50, 1'b0);
        drive(1'b0, 4'h0, 6'd7, 32'hFFFFFFFF, 1'b0, 6'd7, 1'b0);
        idle(3);
        rnd(1500, 0);
        fill();
        drive(1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'd3, 1'b1);
        rnd(9, 0);
        drive(1'b0, 4'hF, 6'd4, 32'hCAFEF00D, 1'b0, 6'd4, 1'b1);
        rnd(60, 0);
        idle(5);
        read_all();
        fill();
        drive(1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 6'd0, 1'b1);
        rnd(29, 0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        rnd(70, 0);
        read_all();
        rnd(1500, 150);
        idle(10);
        chk("drain", 0, 32'(q0.size()), 32'd0);
        chk("drain", 1, 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sram_deltacache_dp.md
Name: sram_deltacache_dp

Overview:
Parametrised simple-dual-port (1 write, 1 read) synchronous SRAM for the delta cache. It is the successor to the single-port delta-cache store.
- Adds byte-lane write enables, a registered read with a valid flag, and an optional extra output pipeline stage.
- Adds a configurable read-during-write bypass.
- Replaces the parallel reset-clear with a sequential clear engine, one word per cycle, reported through clr_busy.

Parameters:
ADDR_WIDTH   6    address width, both ports
DATA_WIDTH   32   word width; must be a multiple of BYTE_W
MEM_DEPTH    64   number of words; must be <= 2**ADDR_WIDTH
BYTE_W       8    bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_W (derived)
OUT_REG      0    0: read latency 1; 1: extra output register, read latency 2
WT_BYPASS    1    1: same-address read-during-write returns new data; 0: returns old data

Ports:
clk        in   1            clock, all logic on rising edge
rst_n      in   1            reset, asynchronous, active-low
clr_req    in   1            pulse: start sequential clear of the whole array
clr_busy   out  1            high while the clear engine runs
wr_cs_n    in   1            write-port select, active-low
wr_be      in   NUM_BYTES    byte-lane write enables, active-high
wr_addr    in   ADDR_WIDTH   write address
wr_data    in   DATA_WIDTH   write data
rd_cs_n    in   1            read-port select, active-low
rd_addr    in   ADDR_WIDTH   read address
rd_data    out  DATA_WIDTH   read data, registered; holds last value between reads
rd_valid   out  1            one-cycle strobe marking new rd_data

Behaviour:
Reset values:
- rd_data=0, rd_valid=0, clr_busy=1; output pipeline cleared.
- FSM enters CLEAR with clear counter=0.
- Array is NOT reset asynchronously; contents are defined only once CLEAR completes.

FSM states: CLEAR, IDLE.
- CLEAR: each cycle writes mem[cnt]=0, then cnt++.
- When cnt==MEM_DEPTH-1, that word is written and the next state is IDLE. The clear takes exactly MEM_DEPTH cycles after rst_n deasserts.
- clr_busy is 1 throughout CLEAR and drops on the first IDLE cycle.
- IDLE + clr_req=1 -> CLEAR with cnt=0; clr_busy rises the next cycle.
- clr_req during CLEAR is ignored; the clear does not restart.
- rst_n asserted mid-clear: the clear restarts from word 0 after release.
- During CLEAR, user writes are dropped and user reads are dropped: no rd_valid and rd_data is unchanged. Reads issued in the last IDLE cycle before CLEAR still complete.

Write (IDLE only, wr_cs_n=0):
- For each lane b with wr_be[b]=1: mem[wr_addr][b*BYTE_W +: BYTE_W] <= wr_data lane b.
- Lanes with wr_be[b]=0 are unchanged; wr_be all-zero is a no-op.
- wr_addr >= MEM_DEPTH: the write is ignored.

Read (IDLE only, rd_cs_n=0):
- Address is sampled at edge N.
- OUT_REG=0: rd_data updates and rd_valid=1 at edge N+1.
- OUT_REG=1: both at edge N+2.
- Back-to-back reads give full throughput, one result per cycle.
- rd_addr >= MEM_DEPTH: the read returns 0 with rd_valid=1.
- No read issued: rd_valid=0 and rd_data holds its previous value.

Read-during-write (same cycle, rd_addr==wr_addr, both selected):
- WT_BYPASS=1: returns the merged word (new bytes where wr_be=1, old bytes elsewhere).
- WT_BYPASS=0: returns the pre-write word.
- A read of an address written in an earlier cycle always returns the updated data.

Independent write and read addresses proceed in the same cycle without interaction.

Test Plan:
- Reset release, default params -> clr_busy=1 for exactly 64 cycles then 0; a read of every address returns 0x00000000 with rd_valid one cycle after each request.
- IDLE: write addr 5 data 0xDEADBEEF be=4'b1111, then write addr 5 data 0x11223344 be=4'b0101, read addr 5 -> rd_data=0xDE22BE44 at latency 1 (latency 2 with OUT_REG=1).
- Same-cycle write addr 9 data 0xA5A5A5A5 be=4'b1111 and read addr 9 (old value 0) -> WT_BYPASS=1: 0xA5A5A5A5; WT_BYPASS=0: 0x00000000, and a following read returns 0xA5A5A5A5.
- Fill the array, pulse clr_req, pulse clr_req again 10 cycles later, and issue writes/reads during the clear -> clr_busy high for exactly 64 cycles with no restart; no rd_valid during the clear; all words read 0 afterwards.
- Assert rst_n at clear cycle 30 -> after release the clear restarts; clr_busy is high for 64 cycles from release.
- MEM_DEPTH=48, ADDR_WIDTH=6: write addr 50 then read addr 50 -> rd_data=0 with rd_valid=1; words 0..47 are unchanged.
